// File: rtl/bitmap_header_stripper_if.sv
// AXI-Stream channel bundle used on both sides of bitmap_header_stripper.
// master drives data/sideband/valid/last, slave drives ready.
interface bitmap_header_stripper_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bitmap_header_stripper.sv
// Strips a fixed-length BMP header from each AXI-Stream packet and lane-aligns the pixel bytes.
// Define BITMAP_HEADER_CHECK_EN to drop packets not starting with "BM" and count them.
module bitmap_header_stripper #(
  parameter int TDATA_WIDTH  = 256,
  parameter int TUSER_WIDTH  = 128,
  parameter int HEADER_BYTES = 54
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  bitmap_header_stripper_if.slave  axis_input,
  bitmap_header_stripper_if.master axis_output
`ifdef BITMAP_HEADER_CHECK_EN
  ,
  output logic [15:0]              bad_header_count
`endif
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int SKIP_BEATS  = HEADER_BYTES / TKEEP_WIDTH;
  localparam int OFF         = HEADER_BYTES % TKEEP_WIDTH;
  localparam int HOLD_BYTES  = TKEEP_WIDTH - OFF;
  localparam int CW          = $clog2(TKEEP_WIDTH + 1) + 1;
  localparam int CNTW        = $clog2(SKIP_BEATS + 2) + 1;

  localparam logic [CW-1:0]          OFF_C    = CW'(OFF);
  localparam logic [CW-1:0]          HOLD_C   = CW'(HOLD_BYTES);
  localparam logic [CNTW-1:0]        SKIP_C   = CNTW'(SKIP_BEATS);
  localparam logic [CNTW-1:0]        CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]        CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [TKEEP_WIDTH-1:0] KEEP_ALL = {TKEEP_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_SKIP  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  function automatic logic [CW-1:0] keep_count(input logic [TKEEP_WIDTH-1:0] k);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      c = c + {{(CW-1){1'b0}}, k[i]};
    end
    return c;
  endfunction

  function automatic logic [TKEEP_WIDTH-1:0] keep_mask(input logic [CW-1:0] n);
    logic [TKEEP_WIDTH-1:0] m;
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      m[i] = (CW'(i) < n);
    end
    return m;
  endfunction

  state_t                 state_r;
  logic [CNTW-1:0]        cnt_r;
  logic [TDATA_WIDTH-1:0] hold_r;
  logic [CW-1:0]          res_r;
  logic [TUSER_WIDTH-1:0] user_r;
  logic [TDATA_WIDTH-1:0] out_data_r;
  logic [TKEEP_WIDTH-1:0] out_keep_r;
  logic [TUSER_WIDTH-1:0] out_user_r;
  logic                   out_valid_r;
  logic                   out_last_r;

  logic                   out_free_s;
  logic                   first_s;
  logic                   payload_s;
  logic                   in_last_s;
  logic                   hdr_bad_s;
  logic                   ready_s;
  logic                   in_fire_s;
  logic [CW-1:0]          n_s;
  logic [TDATA_WIDTH-1:0] shifted_s;
  logic [TDATA_WIDTH-1:0] merged_s;
  logic [TUSER_WIDTH-1:0] pkt_user_s;

  // Handshake qualifiers and byte realignment datapath
  always_comb begin
    out_free_s = !out_valid_r || axis_output.tready;
    first_s    = (state_r == ST_SKIP) && (cnt_r == CNT_ZERO);
    payload_s  = (state_r == ST_SKIP) && (cnt_r == SKIP_C);
    in_last_s  = axis_input.tlast;
    n_s        = keep_count(axis_input.tkeep);
    // Holding register keeps the upper input bytes already moved down to lane 0.
    shifted_s  = axis_input.tdata >> (OFF * 8);
    merged_s   = hold_r | (axis_input.tdata << (HOLD_BYTES * 8));
    pkt_user_s = first_s ? axis_input.tuser : user_r;
`ifdef BITMAP_HEADER_CHECK_EN
    hdr_bad_s  = first_s && ((axis_input.tdata[15:0] != 16'h4D42) || (axis_input.tkeep[1:0] != 2'b11));
`else
    hdr_bad_s  = 1'b0;
`endif
    case (state_r)
      ST_SKIP:  ready_s = payload_s ? out_free_s : 1'b1;
      ST_ALIGN: ready_s = out_free_s;
      ST_FLUSH: ready_s = 1'b0;
      ST_DROP:  ready_s = 1'b1;
      default:  ready_s = 1'b0;
    endcase
    in_fire_s = axis_resetn && ready_s && axis_input.tvalid;
  end

  assign axis_input.tready  = axis_resetn & ready_s;
  assign axis_output.tdata  = out_data_r;
  assign axis_output.tkeep  = out_keep_r;
  assign axis_output.tuser  = out_user_r;
  assign axis_output.tvalid = out_valid_r;
  assign axis_output.tlast  = out_last_r;

  // Packet state machine, holding register and output register
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_r     <= ST_SKIP;
      cnt_r       <= CNT_ZERO;
      hold_r      <= {TDATA_WIDTH{1'b0}};
      res_r       <= {CW{1'b0}};
      user_r      <= {TUSER_WIDTH{1'b0}};
      out_data_r  <= {TDATA_WIDTH{1'b0}};
      out_keep_r  <= {TKEEP_WIDTH{1'b0}};
      out_user_r  <= {TUSER_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
`ifdef BITMAP_HEADER_CHECK_EN
      bad_header_count <= 16'h0000;
`endif
    end else begin
      if (out_valid_r && axis_output.tready) begin
        out_valid_r <= 1'b0;
      end
      if (in_fire_s && first_s) begin
        user_r <= axis_input.tuser;
      end
      case (state_r)
        ST_SKIP: begin
          if (in_fire_s) begin
            if (hdr_bad_s) begin
              cnt_r   <= CNT_ZERO;
              state_r <= in_last_s ? ST_SKIP : ST_DROP;
`ifdef BITMAP_HEADER_CHECK_EN
              if (bad_header_count != 16'hFFFF) begin
                bad_header_count <= bad_header_count + 16'h0001;
              end
`endif
            end else if (!payload_s) begin
              cnt_r <= in_last_s ? CNT_ZERO : cnt_r + CNT_ONE;
            end else begin
              cnt_r <= CNT_ZERO;
              if (OFF == 0) begin
                out_valid_r <= 1'b1;
                out_data_r  <= axis_input.tdata;
                out_keep_r  <= axis_input.tkeep;
                out_last_r  <= in_last_s;
                out_user_r  <= pkt_user_s;
                state_r     <= in_last_s ? ST_SKIP : ST_ALIGN;
              end else if (in_last_s) begin
                // Packet ends in its first payload beat: emit the leftover bytes directly.
                if (n_s > OFF_C) begin
                  out_valid_r <= 1'b1;
                  out_data_r  <= shifted_s;
                  out_keep_r  <= keep_mask(n_s - OFF_C);
                  out_last_r  <= 1'b1;
                  out_user_r  <= pkt_user_s;
                end
                state_r <= ST_SKIP;
              end else begin
                hold_r  <= shifted_s;
                state_r <= ST_ALIGN;
              end
            end
          end
        end
        ST_ALIGN: begin
          if (in_fire_s) begin
            out_valid_r <= 1'b1;
            out_user_r  <= user_r;
            if (OFF == 0) begin
              out_data_r <= axis_input.tdata;
              out_keep_r <= axis_input.tkeep;
              out_last_r <= in_last_s;
              state_r    <= in_last_s ? ST_SKIP : ST_ALIGN;
            end else begin
              out_data_r <= merged_s;
              hold_r     <= shifted_s;
              if (!in_last_s) begin
                out_keep_r <= KEEP_ALL;
                out_last_r <= 1'b0;
              end else if (n_s <= OFF_C) begin
                out_keep_r <= keep_mask(HOLD_C + n_s);
                out_last_r <= 1'b1;
                state_r    <= ST_SKIP;
              end else begin
                out_keep_r <= KEEP_ALL;
                out_last_r <= 1'b0;
                res_r      <= n_s - OFF_C;
                state_r    <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (out_free_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= hold_r;
            out_keep_r  <= keep_mask(res_r);
            out_last_r  <= 1'b1;
            out_user_r  <= user_r;
            state_r     <= ST_SKIP;
          end
        end
        ST_DROP: begin
          if (in_fire_s && in_last_s) begin
            state_r <= ST_SKIP;
          end
        end
        default: begin
          state_r <= ST_SKIP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bitmap_header_stripper.sv
// Randomized scoreboard bench for bitmap_header_stripper against a byte-queue reference model.
module tb_bitmap_header_stripper;
  localparam int TDW = 256;
  localparam int TUW = 128;
  localparam int TK  = TDW / 8;
  localparam int HB  = 54;

  typedef struct {
    logic [TDW-1:0] data;
    logic [TK-1:0]  keep;
    logic           last;
    logic [TUW-1:0] user;
  } beat_t;

  logic axis_aclk = 1'b0;
  logic axis_resetn;
  always #5 axis_aclk = ~axis_aclk;

  bitmap_header_stripper_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) in_if ();
  bitmap_header_stripper_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) out_if ();

`ifdef BITMAP_HEADER_CHECK_EN
  logic [15:0] bad_header_count;
`endif

  bitmap_header_stripper #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .HEADER_BYTES(HB)) dut (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .axis_input  (in_if),
    .axis_output (out_if)
`ifdef BITMAP_HEADER_CHECK_EN
    ,
    .bad_header_count (bad_header_count)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_bad = 0;
  int          exp_beats = 0;
  int          got_beats = 0;
  int          rdy_mode = 0;
  bit          gaps = 1'b0;
  beat_t       exp_q[$];
  logic [7:0]  cur_pkt[$];
  logic [7:0]  pkt1[$];
  logic [TUW-1:0] user1;

  task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [TUW-1:0] rand_user();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_pkt(input int len, input logic [7:0] b0, input logic [7:0] b1);
    cur_pkt.delete();
    for (int i = 0; i < len; i++) cur_pkt.push_back(8'($urandom_range(0, 255)));
    if (len >= 1) cur_pkt[0] = b0;
    if (len >= 2) cur_pkt[1] = b1;
  endtask

  // Reference model: drop the first HB bytes, repack the rest into TK-byte beats.
  task automatic model_push(input logic [TUW-1:0] user);
    int np;
    beat_t e;
`ifdef BITMAP_HEADER_CHECK_EN
    if (cur_pkt.size() < 2 || cur_pkt[0] != 8'h42 || cur_pkt[1] != 8'h4D) begin
      if (exp_bad < 65535) exp_bad++;
      return;
    end
`endif
    np = cur_pkt.size() - HB;
    for (int b = 0; b < np; b += TK) begin
      e.data = {TDW{1'b0}};
      e.keep = {TK{1'b0}};
      for (int j = 0; j < TK && b + j < np; j++) begin
        e.data[8*j +: 8] = cur_pkt[HB + b + j];
        e.keep[j] = 1'b1;
      end
      e.last = (b + TK >= np);
      e.user = user;
      exp_q.push_back(e);
      exp_beats++;
    end
  endtask

  task automatic send_packet(input logic [TUW-1:0] user, input int abort_after, input bit expect_out);
    int nb;
    int w;
    bit ok;
    nb = (cur_pkt.size() + TK - 1) / TK;
    if (expect_out) model_push(user);
    for (int b = 0; b < nb; b++) begin
      if (abort_after > 0 && b == abort_after) break;
      if (gaps) begin
        in_if.tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge axis_aclk); #1; end
      end
      in_if.tdata = {TDW{1'b0}};
      in_if.tkeep = {TK{1'b0}};
      for (int j = 0; j < TK && b * TK + j < cur_pkt.size(); j++) begin
        in_if.tdata[8*j +: 8] = cur_pkt[b * TK + j];
        in_if.tkeep[j] = 1'b1;
      end
      in_if.tuser  = (b == 0) ? user : rand_user();
      in_if.tlast  = (b == nb - 1);
      in_if.tvalid = 1'b1;
      ok = 1'b0;
      w = 0;
      while (!ok && w < 1000) begin
        @(negedge axis_aclk);
        ok = in_if.tready;
        @(posedge axis_aclk);
        #1;
        w++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in_accept_timeout: beat %0d not accepted after %0d cycles", b, w);
      end
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 4000) begin @(posedge axis_aclk); #1; w++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still expected, 0 required", exp_q.size());
    end
    repeat (3) begin @(posedge axis_aclk); #1; end
  endtask

  task automatic check_reset();
    @(negedge axis_aclk);
    check_val("rst_in_tready",  {255'd0, in_if.tready},   256'd0);
    check_val("rst_out_tvalid", {255'd0, out_if.tvalid},  256'd0);
    check_val("rst_out_tlast",  {255'd0, out_if.tlast},   256'd0);
    check_val("rst_out_tkeep",  {224'd0, out_if.tkeep},   256'd0);
    check_val("rst_out_tdata",  out_if.tdata,             256'd0);
    check_val("rst_out_tuser",  {128'd0, out_if.tuser},   256'd0);
    @(posedge axis_aclk);
    #1;
  endtask

  // Output ready generator
  initial begin
    out_if.tready = 1'b0;
    forever begin
      @(posedge axis_aclk);
      #1;
      out_if.tready = (rdy_mode == 0) || ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare every transferred beat against the scoreboard, and check stall stability
  initial begin : monitor
    beat_t e;
    logic [TDW-1:0] m;
    bit prev_stall;
    logic [TDW-1:0] pd;
    logic [TK-1:0]  pk;
    logic           pl;
    logic [TUW-1:0] pu;
    prev_stall = 1'b0;
    forever begin
      @(negedge axis_aclk);
      if (axis_resetn !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_val("stall_stable",
                    {255'd0, (out_if.tvalid === 1'b1) && (out_if.tdata === pd) && (out_if.tkeep === pk)
                             && (out_if.tlast === pl) && (out_if.tuser === pu)}, 256'd1);
        end
        if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
          got_beats++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: keep %0h data %0h with no beat expected", out_if.tkeep, out_if.tdata);
          end else begin
            e = exp_q.pop_front();
            for (int j = 0; j < TK; j++) m[8*j +: 8] = {8{e.keep[j]}};
            check_val("out_tkeep", {224'd0, out_if.tkeep}, {224'd0, e.keep});
            check_val("out_tlast", {255'd0, out_if.tlast}, {255'd0, e.last});
            check_val("out_tuser", {128'd0, out_if.tuser}, {128'd0, e.user});
            check_val("out_tdata", out_if.tdata & m, e.data & m);
          end
        end
        prev_stall = (out_if.tvalid === 1'b1) && (out_if.tready !== 1'b1);
        pd = out_if.tdata;
        pk = out_if.tkeep;
        pl = out_if.tlast;
        pu = out_if.tuser;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TUW-1:0] u;
    int len;
    axis_resetn  = 1'b0;
    in_if.tvalid = 1'b0;
    in_if.tdata  = {TDW{1'b0}};
    in_if.tkeep  = {TK{1'b0}};
    in_if.tuser  = {TUW{1'b0}};
    in_if.tlast  = 1'b0;
    repeat (2) begin @(posedge axis_aclk); #1; end
    check_reset();
    axis_resetn = 1'b1;
    @(posedge axis_aclk);
    #1;
`ifdef BITMAP_HEADER_CHECK_EN
    check_val("bad_count_reset", {240'd0, bad_header_count}, 256'd0);
`endif

    // 118-byte packet, always ready
    build_pkt(118, 8'h42, 8'h4D);
    pkt1 = cur_pkt;
    user1 = rand_user();
    send_packet(user1, 0, 1'b1);
    wait_drain();

    // One payload byte
    build_pkt(55, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    wait_drain();

    // Header-only and sub-header packets, then a valid one
    build_pkt(54, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    build_pkt(40, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    build_pkt(118, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    wait_drain();

    // Short last beat with backpressure; plus residual-flush length
    rdy_mode = 1;
    build_pkt(104, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    build_pkt(120, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    wait_drain();
    rdy_mode = 0;

    // Reset in the middle of a packet, then replay the first packet
    build_pkt(118, 8'h42, 8'h4D);
    send_packet(rand_user(), 2, 1'b0);
    axis_resetn = 1'b0;
    @(posedge axis_aclk);
    #1;
    check_reset();
    axis_resetn = 1'b1;
    cur_pkt = pkt1;
    send_packet(user1, 0, 1'b1);
    wait_drain();

    // Bad magic followed by a good packet
    build_pkt(118, 8'h42, 8'h4E);
    send_packet(rand_user(), 0, 1'b1);
    build_pkt(118, 8'h42, 8'h4D);
    send_packet(rand_user(), 0, 1'b1);
    wait_drain();
`ifdef BITMAP_HEADER_CHECK_EN
    check_val("bad_count_one", {240'd0, bad_header_count}, 256'd1);
`endif

    // Random packets, random gaps and backpressure
    gaps = 1'b1;
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 1);
      len = $urandom_range(1, 220);
      u = rand_user();
      if ($urandom_range(0, 9) == 0) build_pkt(len, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else build_pkt(len, 8'h42, 8'h4D);
      send_packet(u, 0, 1'b1);
    end
    rdy_mode = 1;
    wait_drain();

    check_val("total_beats", 256'(got_beats), 256'(exp_beats));
`ifdef BITMAP_HEADER_CHECK_EN
    check_val("bad_count_final", {240'd0, bad_header_count}, 256'(exp_bad));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
